aes_axi_lite_slave: RTL and testbench

//  AXI4-Lite responder (S00_AXI) for the AES IP; the other end of the master VIP in the BFM design.

---
 rtl/aes_axi_pkg.sv | 42 ++++
 rtl/aes_axi_lite_if.sv | 185 ++++++++++++++++++
 rtl/aes_axi_lite_slave.sv | 175 +++++++++++++++++
 tb/tb_aes_axi_lite_slave.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_axi_pkg.sv
// Shared definitions for the AES AXI4-Lite slave.
// Contents:
//   - word indices (byte address [5:2]) of the register map
//   - AXI response codes
//   - write/read channel FSM state enums
//   - apply_strb(): byte-enable merge helper
package aes_axi_pkg;

  // Word index = byte offset >> 2. Regions are 4 words each, so idx[3:2]
  // selects KEY / DIN / DOUT / control, and idx[1:0] the word within it.
  localparam logic [3:0] IDX_KEY0   = 4'h0;  // 0x00-0x0C
  localparam logic [3:0] IDX_DIN0   = 4'h4;  // 0x10-0x1C
  localparam logic [3:0] IDX_DOUT0  = 4'h8;  // 0x20-0x2C
  localparam logic [3:0] IDX_CTRL   = 4'hC;  // 0x30
  localparam logic [3:0] IDX_STATUS = 4'hD;  // 0x34

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_t;

  function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/aes_axi_lite_if.sv
// AXI4-Lite channel front end: write and read FSMs plus handshakes.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_aw*/o_awready, i_w*/o_wready write address / data channels
//   o_bresp, o_bvalid, i_bready    write response channel
//   i_ar*/o_arready                read address channel
//   o_rdata, o_rresp, o_rvalid, i_rready  read data channel
//   o_wr_en/addr/data/strb, i_wr_err      one-cycle register write request
//   o_rd_addr, i_rd_data, i_rd_err        combinational read lookup
//   o_wr_state, o_rd_state                FSM state taps
// Handshake rule: a beat transfers on a rising edge where valid and ready
// are both high; a source keeps valid and payload stable until then.
module aes_axi_lite_if
  import aes_axi_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [5:0]  i_awaddr,
  input  logic        i_awvalid,
  output logic        o_awready,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_wvalid,
  output logic        o_wready,
  output logic [1:0]  o_bresp,
  output logic        o_bvalid,
  input  logic        i_bready,
  input  logic [5:0]  i_araddr,
  input  logic        i_arvalid,
  output logic        o_arready,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rvalid,
  input  logic        i_rready,
  output logic        o_wr_en,
  output logic [5:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic [3:0]  o_wr_strb,
  input  logic        i_wr_err,
  output logic [5:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  input  logic        i_rd_err,
  output wr_state_t   o_wr_state,
  output rd_state_t   o_rd_state
);

  wr_state_t   r_wr_state;
  rd_state_t   r_rd_state;
  logic        r_awready, r_wready, r_bvalid, r_wr_en;
  logic [1:0]  r_bresp;
  logic [5:0]  r_wr_addr;
  logic [31:0] r_wr_data;
  logic [3:0]  r_wr_strb;
  logic        r_arready, r_rvalid;
  logic [1:0]  r_rresp;
  logic [31:0] r_rdata;

  logic w_aw_hs, w_w_hs;
  assign w_aw_hs = i_awvalid && r_awready;
  assign w_w_hs  = i_wvalid  && r_wready;

  // Write FSM. r_wr_en is raised on the edge that completes the second
  // beat, so the register file updates during the first W_RESP cycle and
  // bvalid (with the error verdict for that access) rises one edge later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_state <= W_IDLE;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_bvalid   <= 1'b0;
      r_bresp    <= AXI_RESP_OKAY;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_strb  <= '0;
    end else begin
      r_wr_en <= 1'b0;
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_wr_addr <= i_awaddr;
            r_awready <= 1'b0;
          end else begin
            r_awready <= 1'b1;
          end
          if (w_w_hs) begin
            r_wr_data <= i_wdata;
            r_wr_strb <= i_wstrb;
            r_wready  <= 1'b0;
          end else begin
            r_wready  <= 1'b1;
          end
          if (w_aw_hs && w_w_hs) begin
            r_wr_en    <= 1'b1;
            r_wr_state <= W_RESP;
          end else if (w_aw_hs) begin
            r_wr_state <= W_HAVE_AW;
          end else if (w_w_hs) begin
            r_wr_state <= W_HAVE_W;
          end
        end
        W_HAVE_AW: begin
          if (w_w_hs) begin
            r_wr_data  <= i_wdata;
            r_wr_strb  <= i_wstrb;
            r_wready   <= 1'b0;
            r_wr_en    <= 1'b1;
            r_wr_state <= W_RESP;
          end
        end
        W_HAVE_W: begin
          if (w_aw_hs) begin
            r_wr_addr  <= i_awaddr;
            r_awready  <= 1'b0;
            r_wr_en    <= 1'b1;
            r_wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (r_wr_en) begin
            r_bvalid <= 1'b1;
            r_bresp  <= i_wr_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
          end else if (r_bvalid && i_bready) begin
            r_bvalid   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= W_IDLE;
          end
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM. arready is raised the cycle after arvalid appears and drops
  // on the accepting edge; that same edge captures the lookup for araddr,
  // so a write landing on the same edge is not yet visible to the read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_state <= R_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rresp    <= AXI_RESP_OKAY;
      r_rdata    <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (i_arvalid && r_arready) begin
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= i_rd_err ? 32'h0 : i_rd_data;
            r_rresp    <= i_rd_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            r_rd_state <= R_DATA;
          end else if (i_arvalid) begin
            r_arready  <= 1'b1;
          end
        end
        R_DATA: begin
          if (i_rready) begin
            r_rvalid   <= 1'b0;
            r_rd_state <= R_IDLE;
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign o_awready  = r_awready;
  assign o_wready   = r_wready;
  assign o_bvalid   = r_bvalid;
  assign o_bresp    = r_bresp;
  assign o_arready  = r_arready;
  assign o_rvalid   = r_rvalid;
  assign o_rresp    = r_rresp;
  assign o_rdata    = r_rdata;
  assign o_wr_en    = r_wr_en;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_data  = r_wr_data;
  assign o_wr_strb  = r_wr_strb;
  assign o_rd_addr  = i_araddr;
  assign o_wr_state = r_wr_state;
  assign o_rd_state = r_rd_state;

endmodule

// File: rtl/aes_axi_lite_slave.sv
// AXI4-Lite register slave for the AES core.
// Ports:
//   s00_axi_*     AXI4-Lite slave (6-bit byte address, 32-bit data)
//   aes_key_o     {KEY3,KEY2,KEY1,KEY0}
//   aes_data_o    {DIN3,DIN2,DIN1,DIN0}
//   aes_start_o   one-cycle start pulse
//   aes_data_i    ciphertext, valid with aes_done_i
//   aes_done_i    one-cycle completion pulse
//   irq_o         STATUS.done & CTRL.ie
// Holds the register file, start/busy/done tracking and the interrupt.
module aes_axi_lite_slave
  import aes_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [127:0]                    aes_key_o,
  output logic [127:0]                    aes_data_o,
  output logic                            aes_start_o,
  input  logic [127:0]                    aes_data_i,
  input  logic                            aes_done_i,
  output logic                            irq_o
);

  logic        w_wr_en, w_wr_err, w_rd_err;
  logic [5:0]  w_wr_addr, w_rd_addr;
  logic [31:0] w_wr_data, w_rd_data;
  logic [3:0]  w_wr_strb, w_wr_idx, w_rd_idx;
  wr_state_t   w_wr_state;
  rd_state_t   w_rd_state;

  logic [31:0] r_key  [4];
  logic [31:0] r_din  [4];
  logic [31:0] r_dout [4];
  logic        r_ie, r_busy, r_done, r_start;

  aes_axi_lite_if u_if (
    .i_clk      (s00_axi_aclk),
    .i_rst_n    (s00_axi_aresetn),
    .i_awaddr   (s00_axi_awaddr),
    .i_awvalid  (s00_axi_awvalid),
    .o_awready  (s00_axi_awready),
    .i_wdata    (s00_axi_wdata),
    .i_wstrb    (s00_axi_wstrb),
    .i_wvalid   (s00_axi_wvalid),
    .o_wready   (s00_axi_wready),
    .o_bresp    (s00_axi_bresp),
    .o_bvalid   (s00_axi_bvalid),
    .i_bready   (s00_axi_bready),
    .i_araddr   (s00_axi_araddr),
    .i_arvalid  (s00_axi_arvalid),
    .o_arready  (s00_axi_arready),
    .o_rdata    (s00_axi_rdata),
    .o_rresp    (s00_axi_rresp),
    .o_rvalid   (s00_axi_rvalid),
    .i_rready   (s00_axi_rready),
    .o_wr_en    (w_wr_en),
    .o_wr_addr  (w_wr_addr),
    .o_wr_data  (w_wr_data),
    .o_wr_strb  (w_wr_strb),
    .i_wr_err   (w_wr_err),
    .o_rd_addr  (w_rd_addr),
    .i_rd_data  (w_rd_data),
    .i_rd_err   (w_rd_err),
    .o_wr_state (w_wr_state),
    .o_rd_state (w_rd_state)
  );

  // Byte lanes are ignored; prot is not used. FSM state taps stay available
  // on the sub-module for checker binding.
  logic w_unused_ok;
  assign w_unused_ok = ^{s00_axi_awprot, s00_axi_arprot, w_wr_addr[1:0],
                         w_rd_addr[1:0], w_wr_state, w_rd_state};

  assign w_wr_idx = w_wr_addr[5:2];
  assign w_rd_idx = w_rd_addr[5:2];

  // Write error: DOUT is read-only, 0x38/0x3C are unmapped, and the key
  // and plaintext must not change under the core while it runs.
  always_comb begin
    w_wr_err = 1'b0;
    case (w_wr_idx[3:2])
      2'b00, 2'b01: w_wr_err = r_busy;
      2'b10:        w_wr_err = 1'b1;
      default:      w_wr_err = w_wr_idx[1];
    endcase
  end

  assign w_rd_err = (w_rd_idx[3:2] == 2'b11) && w_rd_idx[1];

  always_comb begin
    w_rd_data = '0;
    case (w_rd_idx[3:2])
      2'b00: w_rd_data = r_key[w_rd_idx[1:0]];
      2'b01: w_rd_data = r_din[w_rd_idx[1:0]];
      2'b10: w_rd_data = r_dout[w_rd_idx[1:0]];
      default: begin
        if (w_rd_idx == IDX_CTRL)   w_rd_data = {30'h0, r_ie, 1'b0};
        if (w_rd_idx == IDX_STATUS) w_rd_data = {30'h0, r_done, r_busy};
      end
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < 4; i++) begin
        r_key[i]  <= '0;
        r_din[i]  <= '0;
        r_dout[i] <= '0;
      end
      r_ie    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_start <= 1'b0;
      if (w_wr_en && !w_wr_err) begin
        case (w_wr_idx[3:2])
          2'b00: r_key[w_wr_idx[1:0]] <= apply_strb(r_key[w_wr_idx[1:0]], w_wr_data, w_wr_strb);
          2'b01: r_din[w_wr_idx[1:0]] <= apply_strb(r_din[w_wr_idx[1:0]], w_wr_data, w_wr_strb);
          2'b11: begin
            if (w_wr_idx == IDX_CTRL && w_wr_strb[0]) begin
              r_ie <= w_wr_data[1];
              // A start request while the core runs is silently dropped.
              if (w_wr_data[0] && !r_busy) begin
                r_start <= 1'b1;
                r_busy  <= 1'b1;
              end
            end
            if (w_wr_idx == IDX_STATUS && w_wr_strb[0] && w_wr_data[1]) begin
              r_done <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      // Placed after the W1C so a coincident completion leaves done set.
      if (aes_done_i && r_busy) begin
        r_dout[0] <= aes_data_i[31:0];
        r_dout[1] <= aes_data_i[63:32];
        r_dout[2] <= aes_data_i[95:64];
        r_dout[3] <= aes_data_i[127:96];
        r_busy    <= 1'b0;
        r_done    <= 1'b1;
      end
    end
  end

  assign aes_key_o   = {r_key[3], r_key[2], r_key[1], r_key[0]};
  assign aes_data_o  = {r_din[3], r_din[2], r_din[1], r_din[0]};
  assign aes_start_o = r_start;
  assign irq_o       = r_done & r_ie;

endmodule

// File: tb/tb_aes_axi_lite_slave.sv
module tb_aes_axi_lite_slave;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [5:0]   awaddr = '0, araddr = '0;
  logic [2:0]   awprot = '0, arprot = '0;
  logic         awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [31:0]  wdata = '0;
  logic [3:0]   wstrb = '0;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [127:0] aes_key, aes_din, core_dout = '0;
  logic         aes_start, core_done = 0, irq;

  aes_axi_lite_slave dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi_awaddr  (awaddr),
    .s00_axi_awprot  (awprot),
    .s00_axi_awvalid (awvalid),
    .s00_axi_awready (awready),
    .s00_axi_wdata   (wdata),
    .s00_axi_wstrb   (wstrb),
    .s00_axi_wvalid  (wvalid),
    .s00_axi_wready  (wready),
    .s00_axi_bresp   (bresp),
    .s00_axi_bvalid  (bvalid),
    .s00_axi_bready  (bready),
    .s00_axi_araddr  (araddr),
    .s00_axi_arprot  (arprot),
    .s00_axi_arvalid (arvalid),
    .s00_axi_arready (arready),
    .s00_axi_rdata   (rdata),
    .s00_axi_rresp   (rresp),
    .s00_axi_rvalid  (rvalid),
    .s00_axi_rready  (rready),
    .aes_key_o       (aes_key),
    .aes_data_o      (aes_din),
    .aes_start_o     (aes_start),
    .aes_data_i      (core_dout),
    .aes_done_i      (core_done),
    .irq_o           (irq)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0]  exp_b_q[$];
  logic [33:0] exp_r_q[$];   // {rresp, rdata}
  int start_pulses = 0, start_len = 0, max_start_len = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out after 50 cycles", name);
  endtask

  // Monitor: pops expectations on each completed B/R handshake, checks that
  // a stalled B response stays stable, and measures start pulses.
  logic       prev_bwait = 1'b0;
  logic [1:0] prev_bresp = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_bwait) begin
        chk("bvalid_held", bvalid, 1'b1);
        chk("bresp_held", bresp, prev_bresp);
      end
      prev_bwait = bvalid && !bready;
      prev_bresp = bresp;
      if (bvalid && bready) begin
        if (exp_b_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL b_unexpected: got bresp %0d with nothing expected", bresp);
        end else chk("bresp", bresp, exp_b_q.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_r_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL r_unexpected: got rdata 0x%0h with nothing expected", rdata);
        end else begin
          logic [33:0] e;
          e = exp_r_q.pop_front();
          chk("rdata", rdata, e[31:0]);
          chk("rresp", rresp, e[33:32]);
        end
      end
      if (aes_start) begin
        start_len++;
        if (start_len == 1) start_pulses++;
        if (start_len > max_start_len) max_start_len = start_len;
      end else start_len = 0;
    end else begin
      prev_bwait = 1'b0;
      start_len  = 0;
    end
  end

  // ---------------- driver tasks (start and end just after a posedge) ----------------
  task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_lead, input int w_lead, input int b_delay,
                           input logic [1:0] exp_resp);
    exp_b_q.push_back(exp_resp);
    bready = 1'b0;
    fork
      begin : aw_branch
        int k;
        if (aw_lead > 0) begin repeat (aw_lead) @(posedge clk); #1; end
        awaddr = addr; awvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!awready && k < 50) begin @(negedge clk); k++; end
        if (!awready) timeout("aw_ready");
        @(posedge clk); #1; awvalid = 1'b0;
      end
      begin : w_branch
        int k;
        if (w_lead > 0) begin repeat (w_lead) @(posedge clk); #1; end
        wdata = data; wstrb = strb; wvalid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!wready && k < 50) begin @(negedge clk); k++; end
        if (!wready) timeout("w_ready");
        @(posedge clk); #1; wvalid = 1'b0;
      end
    join
    if (b_delay > 0) begin repeat (b_delay) @(posedge clk); #1; end
    bready = 1'b1;
    begin : b_wait
      int k;
      k = 0;
      @(negedge clk);
      while (!bvalid && k < 50) begin @(negedge clk); k++; end
      if (!bvalid) timeout("b_valid");
    end
    @(posedge clk); #1; bready = 1'b0;
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data, input logic [1:0] exp_resp);
    axi_write(addr, data, 4'hF, 0, 0, 0, exp_resp);
  endtask

  task automatic rd(input logic [5:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int k;
    exp_r_q.push_back({exp_resp, exp_data});
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!arready && k < 50) begin @(negedge clk); k++; end
    if (!arready) timeout("ar_ready");
    @(posedge clk); #1; arvalid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!rvalid && k < 50) begin @(negedge clk); k++; end
    if (!rvalid) timeout("r_valid");
    @(posedge clk); #1; rready = 1'b0;
  endtask

  task automatic core_pulse(input logic [127:0] ct);
    @(posedge clk); #1; core_dout = ct; core_done = 1'b1;
    @(posedge clk); #1; core_done = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_arready", arready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_resp", {bresp, rresp}, 0);
    chk("rst_start", aes_start, 0);
    chk("rst_irq", irq, 0);
    chk("rst_key", aes_key, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // 1. key registers write/read-back
    for (int i = 0; i < 4; i++) wr(6'(4 * i), 32'(i + 1), OKAY);
    for (int i = 0; i < 4; i++) rd(6'(4 * i), 32'(i + 1), OKAY);
    chk("key_out", aes_key, 128'h00000004_00000003_00000002_00000001);
    // byte strobe: only byte 1 of KEY0 changes
    axi_write(6'h00, 32'hAABBCCDD, 4'b0010, 0, 0, 0, OKAY);
    rd(6'h00, 32'h0000CC01, OKAY);

    // 2. W before AW, then AW before W with a stalled B
    axi_write(6'h10, 32'hDEADBEEF, 4'hF, 3, 0, 0, OKAY);
    axi_write(6'h14, 32'h12345678, 4'hF, 0, 3, 7, OKAY);
    rd(6'h10, 32'hDEADBEEF, OKAY);
    rd(6'h14, 32'h12345678, OKAY);

    // 3. FIPS-197 vector
    wr(6'h00, 32'h0C0D0E0F, OKAY);
    wr(6'h04, 32'h08090A0B, OKAY);
    wr(6'h08, 32'h04050607, OKAY);
    wr(6'h0C, 32'h00010203, OKAY);
    wr(6'h10, 32'hCCDDEEFF, OKAY);
    wr(6'h14, 32'h8899AABB, OKAY);
    wr(6'h18, 32'h44556677, OKAY);
    wr(6'h1C, 32'h00112233, OKAY);
    chk("fips_key", aes_key, 128'h00010203_04050607_08090A0B_0C0D0E0F);
    chk("fips_din", aes_din, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    wr(6'h30, 32'h1, OKAY);
    chk("start_pulses", start_pulses, 1);
    chk("start_width", max_start_len, 1);
    rd(6'h34, 32'h1, OKAY);
    rd(6'h30, 32'h0, OKAY);

    // 4. while busy
    wr(6'h00, 32'hFFFFFFFF, SLVERR);
    rd(6'h00, 32'h0C0D0E0F, OKAY);
    wr(6'h10, 32'hFFFFFFFF, SLVERR);
    wr(6'h30, 32'h1, OKAY);
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart", start_pulses, 1);
    core_pulse(128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A);
    rd(6'h20, 32'h70B4C55A, OKAY);
    rd(6'h24, 32'hD8CDB780, OKAY);
    rd(6'h28, 32'h6A7B0430, OKAY);
    rd(6'h2C, 32'h69C4E0D8, OKAY);
    rd(6'h34, 32'h2, OKAY);
    // completion while idle is ignored
    core_pulse(128'h1);
    rd(6'h20, 32'h70B4C55A, OKAY);

    // 5. read-only and unmapped
    wr(6'h20, 32'h0, SLVERR);
    rd(6'h20, 32'h70B4C55A, OKAY);
    wr(6'h38, 32'h5, SLVERR);
    rd(6'h38, 32'h0, SLVERR);
    rd(6'h3C, 32'h0, SLVERR);

    // 6. interrupt and done W1C
    wr(6'h30, 32'h2, OKAY);
    chk("irq_on", irq, 1);
    wr(6'h34, 32'h2, OKAY);
    chk("irq_cleared", irq, 0);
    rd(6'h34, 32'h0, OKAY);
    wr(6'h30, 32'h3, OKAY);
    chk("start_pulses_2", start_pulses, 2);
    rd(6'h34, 32'h1, OKAY);
    // W1C of done lands in the same cycle as the core's done pulse
    exp_b_q.push_back(OKAY);
    awaddr = 6'h34; wdata = 32'h2; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge clk);
    chk("coinc_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    core_dout = 128'h11111111_22222222_33333333_44444444; core_done = 1'b1;
    @(posedge clk); #1; core_done = 1'b0;
    begin : coinc_b
      int k;
      k = 0;
      @(negedge clk);
      while (!bvalid && k < 50) begin @(negedge clk); k++; end
      if (!bvalid) timeout("coinc_b");
    end
    @(posedge clk); #1; bready = 1'b0;
    rd(6'h34, 32'h2, OKAY);
    chk("irq_coinc", irq, 1);
    rd(6'h20, 32'h44444444, OKAY);

    // Reset while a B response is pending
    awaddr = 6'h04; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
    begin : pend_b
      int k;
      k = 0;
      @(negedge clk);
      while (!bvalid && k < 50) begin @(negedge clk); k++; end
      if (!bvalid) timeout("pending_b");
    end
    #1; rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_ready", {awready, wready, arready}, 0);
    chk("mid_rst_irq", irq, 0);
    chk("mid_rst_key", aes_key, 0);
    chk("mid_rst_din", aes_din, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(posedge clk); #1;
    rd(6'h04, 32'h0, OKAY);
    rd(6'h20, 32'h0, OKAY);
    rd(6'h30, 32'h0, OKAY);
    rd(6'h34, 32'h0, OKAY);

    repeat (3) @(posedge clk);
    #1;
    chk("b_queue_empty", exp_b_q.size(), 0);
    chk("r_queue_empty", exp_r_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, %0d tests run so far", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
